mips150_lsu: RTL and testbench
==============================

// Module: mips150_lsu
// PURPOSE
//  Parametrised load/store unit for the MIPS150 M stage; handles LB/LH/LW/LBU/LHU
//  and SB/SH/SW. Accepts ops from the X stage, issues word-aligned requests with
//  byte enables to a variable-latency data memory, and tracks outstanding loads.
//  Extracts big-endian lanes, sign/zero-extends them and writes back to the RegFile.
// PARAMETERS
//  DATA_W     32  memory bus width; 32 or 64 only
//  ADDR_W     32  byte address width
//  MAX_OUT    2   max outstanding loads (pending FIFO depth, >=1)
// PORTS
//  clk            in   1        clock
//  rst            in   1        async active-high reset
//  req_valid      in   1        op valid from X stage
//  req_ready      out  1        LSU can accept op this cycle
//  req_op         in   3        000 LB,001 LH,010 LW,011 LBU,100 LHU,101 SB,110 SH,111 SW
//  req_addr       in   ADDR_W   byte address (ALU output)
//  req_wdata      in   32       store data (rt)
//  req_rd         in   5        load destination register
//  mem_req_valid  out  1        memory request valid
//  mem_req_ready  in   1        memory accepts request
//  mem_addr       out  ADDR_W   req_addr with low log2(DATA_W/8) bits zeroed
//  mem_we         out  DATA_W/8 byte write enables; MSB = lane 0 (big-endian); 0 for loads
//  mem_wdata      out  DATA_W   replicated store data
//  mem_rsp_valid  in   1        load data valid, in issue order
//  mem_rdata      in   DATA_W   load data
//  wb_valid       out  1        writeback strobe (1-cycle pulse)
//  wb_rd          out  5        writeback register
//  wb_data        out  32       extended load result
//  misalign_err   out  1        1-cycle pulse for a misaligned op
//  proto_err      out  1        sticky; set on mem_rsp_valid with no pending load
// BEHAVIOUR
//  - Reset (async): mem_req_valid, wb_valid, misalign_err, proto_err = 0;
//    pending count = 0; FIFO pointers = 0; wb_rd/wb_data = 0.
//  - Handshake: accept = req_valid & req_ready. Request stage is one register:
//    mem_req_* load on accept and hold until mem_req_valid & mem_req_ready.
//  - req_ready = (!mem_req_valid | mem_req_ready) & (pending < MAX_OUT).
//    pending is registered only: no same-cycle pop bypass when full.
//  - Latency: mem_req_valid rises the cycle after accept.
//  - pending counts loads accepted but not yet responded, including the one held
//    in the request register. +1 on load accept, -1 on mem_rsp_valid; both -> unchanged.
//  - FIFO stores {op, byte offset, rd} per load; written on accept, popped on response.
//  - Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0.
//  - Misaligned op: still accepted (consumes req_ready), never issued, no FIFO push.
//    misalign_err pulses the next cycle.
//  - Lane select: byte offset = addr[log2(DATA_W/8)-1:0]; offset 0 -> bits [DATA_W-1 -: 8].
//  - Loads: LB/LH sign-extend, LBU/LHU zero-extend, LW passes 32 bits.
//  - Stores: SB sets 1 enable bit; SH 2; SW 4 (DATA_W=64: upper/lower word by addr[2]).
//    wdata is replicated: byte x(DATA_W/8), half x(DATA_W/16), word x(DATA_W/32).
//  - mem_rsp_valid with pending==0: ignored, no wb_valid, proto_err set until reset.
//  - Reset mid-operation discards all pending loads. Late responses then follow
//    the proto_err rule.
// CONFIGURATION
//  LSU_WB_REG_EN defined: wb_valid/wb_rd/wb_data are registered; load-to-wb latency is
//    1 cycle after mem_rsp_valid.
//  LSU_WB_REG_EN undefined: wb_* are combinational from the FIFO head and mem_rdata;
//    wb_valid = mem_rsp_valid & (pending!=0), same cycle.
// TESTING
//  1. DATA_W=32, rdata=32'h8123_45F6: LB off0 -> FFFF_FF81; LBU off3 -> 0000_00F6;
//     LH off2 -> 0000_45F6; LW -> 8123_45F6.
//  2. SB addr 0x13, wdata 0xAB -> mem_addr 0x10, mem_we 4'b0001, mem_wdata AB_AB_AB_AB;
//     SH addr 0x12 -> mem_we 4'b0011.
//  3. LW addr 0x06 -> req_ready=1, no mem_req_valid, misalign_err pulse next cycle,
//     no wb_valid.
//  4. MAX_OUT=2: issue 2 loads, delay responses -> req_ready=0. Response in cycle N ->
//     req_ready=1 in N+1. wb_rd values match issue order.
//  5. mem_req_ready held 0 for 5 cycles -> mem_* stable, req_ready=0 throughout.
//  6. Assert rst with 1 load pending, then mem_rsp_valid -> no wb_valid, proto_err=1.
//     Repeat tests 1 and 4 with DATA_W=64 and with LSU_WB_REG_EN defined.

Source files
------------

// File: rtl/mips150_lsu.sv
// MIPS150 M-stage load/store unit: one-deep request register, in-order pending-load FIFO,
// big-endian lane extract/replicate. Define LSU_WB_REG_EN to register the writeback outputs.
module mips150_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int MAX_OUT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [4:0]          req_rd,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_we,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                wb_valid,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_data,
  output logic                misalign_err,
  output logic                proto_err
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  // Enable masks aligned to lane 0 (MSB); shifted right by the byte offset.
  localparam logic [BYTES-1:0] ALL_B  = {BYTES{1'b1}};
  localparam logic [BYTES-1:0] B_MASK = ~(ALL_B >> 1);
  localparam logic [BYTES-1:0] H_MASK = ~(ALL_B >> 2);
  localparam logic [BYTES-1:0] W_MASK = ~(ALL_B >> 4);

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LH  = 3'b001,
    OP_LW  = 3'b010,
    OP_LBU = 3'b011,
    OP_LHU = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } lsuOp_t;

  typedef struct packed {
    lsuOp_t           op;
    logic [OFF_W-1:0] off;
    logic [4:0]       rd;
  } pendEntry_t;

  lsuOp_t              reqOp;
  logic [OFF_W-1:0]    reqOff;
  logic                isLoad;
  logic                misaligned;
  logic [BYTES-1:0]    weNext;
  logic [DATA_W-1:0]   wdataNext;
  logic                accept;
  logic                pushLoad;
  logic                popRsp;
  logic [CNT_W-1:0]    pending;
  logic [PTR_W-1:0]    wrPtr;
  logic [PTR_W-1:0]    rdPtr;
  pendEntry_t          fifoMem [MAX_OUT];
  pendEntry_t          head;
  logic [DATA_W-1:0]   shifted;
  logic [31:0]         topWord;
  logic [31:0]         extData;
  logic                wbValidNext;
  logic [4:0]          wbRdNext;
  logic [31:0]         wbDataNext;

  assign reqOp  = lsuOp_t'(req_op);
  assign reqOff = req_addr[OFF_W-1:0];

  always_comb begin
    isLoad     = 1'b1;
    misaligned = 1'b0;
    weNext     = '0;
    wdataNext  = {(DATA_W/32){req_wdata}};
    unique case (reqOp)
      OP_LB, OP_LBU: ;
      OP_LH, OP_LHU: misaligned = req_addr[0];
      OP_LW:         misaligned = |req_addr[1:0];
      OP_SB: begin
        isLoad    = 1'b0;
        weNext    = B_MASK >> reqOff;
        wdataNext = {(DATA_W/8){req_wdata[7:0]}};
      end
      OP_SH: begin
        isLoad     = 1'b0;
        misaligned = req_addr[0];
        weNext     = H_MASK >> reqOff;
        wdataNext  = {(DATA_W/16){req_wdata[15:0]}};
      end
      OP_SW: begin
        isLoad     = 1'b0;
        misaligned = |req_addr[1:0];
        weNext     = W_MASK >> reqOff;
      end
    endcase
  end

  // Ready depends only on registered state, so a full FIFO stays blocked in the response cycle.
  assign req_ready = (!mem_req_valid || mem_req_ready) && (pending < CNT_W'(MAX_OUT));
  assign accept    = req_valid && req_ready;
  assign pushLoad  = accept && isLoad && !misaligned;
  assign popRsp    = mem_rsp_valid && (pending != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= '0;
      mem_wdata     <= '0;
    end else if (accept && !misaligned) begin
      mem_req_valid <= 1'b1;
      mem_addr      <= {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
      mem_we        <= weNext;
      mem_wdata     <= wdataNext;
    end else if (mem_req_ready) begin
      mem_req_valid <= 1'b0;
    end
  end

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUT - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending      <= '0;
      wrPtr        <= '0;
      rdPtr        <= '0;
      misalign_err <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      if (pushLoad) wrPtr <= nextPtr(wrPtr);
      if (popRsp)   rdPtr <= nextPtr(rdPtr);
      if (pushLoad && !popRsp)      pending <= pending + CNT_W'(1);
      else if (!pushLoad && popRsp) pending <= pending - CNT_W'(1);
      misalign_err <= accept && misaligned;
      if (mem_rsp_valid && (pending == '0)) proto_err <= 1'b1;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and pending count alone decide validity.
  always_ff @(posedge clk) begin
    if (pushLoad) fifoMem[wrPtr] <= '{op: reqOp, off: reqOff, rd: req_rd};
  end

  assign head    = fifoMem[rdPtr];
  assign shifted = mem_rdata << {head.off, 3'b000};
  assign topWord = shifted[DATA_W-1 -: 32];

  always_comb begin
    extData = '0;
    case (head.op)
      OP_LB:   extData = {{24{topWord[31]}}, topWord[31:24]};
      OP_LBU:  extData = {24'h0, topWord[31:24]};
      OP_LH:   extData = {{16{topWord[31]}}, topWord[31:16]};
      OP_LHU:  extData = {16'h0, topWord[31:16]};
      OP_LW:   extData = topWord;
      default: extData = '0;
    endcase
  end

  // rd/data are forced to zero when no writeback is happening.
  assign wbValidNext = popRsp;
  assign wbRdNext    = popRsp ? head.rd : 5'd0;
  assign wbDataNext  = popRsp ? extData : 32'd0;

`ifdef LSU_WB_REG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
    end else begin
      wb_valid <= wbValidNext;
      wb_rd    <= wbRdNext;
      wb_data  <= wbDataNext;
    end
  end
`else
  assign wb_valid = wbValidNext;
  assign wb_rd    = wbRdNext;
  assign wb_data  = wbDataNext;
`endif

endmodule

// File: tb/tb_mips150_lsu.sv
// Directed bench for mips150_lsu: a 32-bit and a 64-bit instance share one op/response stream;
// expected values are hand-computed per instance. Follows LSU_WB_REG_EN for writeback timing.
module tb_mips150_lsu;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b011,
                         LHU = 3'b100, SB = 3'b101, SH = 3'b110, SW = 3'b111;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] rdata32;
  logic [63:0] rdata64;

  logic        reqReady32, memReqValid32, wbValid32, misalignErr32, protoErr32;
  logic [31:0] memAddr32, memWdata32, wbData32;
  logic [3:0]  memWe32;
  logic [4:0]  wbRd32;

  logic        reqReady64, memReqValid64, wbValid64, misalignErr64, protoErr64;
  logic [31:0] memAddr64, wbData64;
  logic [63:0] memWdata64;
  logic [7:0]  memWe64;
  logic [4:0]  wbRd64;

  int checkCount = 0;
  int errorCount = 0;

  mips150_lsu #(.DATA_W(32), .ADDR_W(32), .MAX_OUT(2)) dut32 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(reqReady32), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(memReqValid32), .mem_req_ready(mem_req_ready), .mem_addr(memAddr32),
    .mem_we(memWe32), .mem_wdata(memWdata32),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(rdata32),
    .wb_valid(wbValid32), .wb_rd(wbRd32), .wb_data(wbData32),
    .misalign_err(misalignErr32), .proto_err(protoErr32)
  );

  mips150_lsu #(.DATA_W(64), .ADDR_W(32), .MAX_OUT(2)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(reqReady64), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req_valid(memReqValid64), .mem_req_ready(mem_req_ready), .mem_addr(memAddr64),
    .mem_we(memWe64), .mem_wdata(memWdata64),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(rdata64),
    .wb_valid(wbValid64), .wb_rd(wbRd64), .wb_data(wbData64),
    .misalign_err(misalignErr64), .proto_err(protoErr64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents one op; called just after a falling edge, returns just after the next one.
  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    #1;
    check({tag, " ready32"}, reqReady32, 1);
    check({tag, " ready64"}, reqReady64, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic checkReq(input string tag, input logic [31:0] a32, input logic [3:0] we32,
                          input logic [31:0] a64, input logic [7:0] we64);
    check({tag, " mvalid32"}, memReqValid32, 1);
    check({tag, " maddr32"}, memAddr32, a32);
    check({tag, " mwe32"}, memWe32, we32);
    check({tag, " mvalid64"}, memReqValid64, 1);
    check({tag, " maddr64"}, memAddr64, a64);
    check({tag, " mwe64"}, memWe64, we64);
  endtask

  task automatic respond(input string tag, input logic [31:0] r32, input logic [63:0] r64,
                         input logic [4:0] rd, input logic [31:0] e32, input logic [31:0] e64);
    mem_rsp_valid = 1'b1;
    rdata32       = r32;
    rdata64       = r64;
`ifdef LSU_WB_REG_EN
    @(negedge clk);
    mem_rsp_valid = 1'b0;
`else
    #1;
`endif
    check({tag, " wbv32"}, wbValid32, 1);
    check({tag, " wbrd32"}, wbRd32, rd);
    check({tag, " wbdata32"}, wbData32, e32);
    check({tag, " wbv64"}, wbValid64, 1);
    check({tag, " wbrd64"}, wbRd64, rd);
    check({tag, " wbdata64"}, wbData64, e64);
`ifdef LSU_WB_REG_EN
    @(negedge clk);
`else
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    #1;
`endif
    check({tag, " wbv32 end"}, wbValid32, 0);
    check({tag, " wbv64 end"}, wbValid64, 0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_op = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_req_ready = 1'b1; mem_rsp_valid = 1'b0; rdata32 = '0; rdata64 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst mvalid32", memReqValid32, 0);
    check("rst mvalid64", memReqValid64, 0);
    check("rst wbv32", wbValid32, 0);
    check("rst wbrd32", wbRd32, 0);
    check("rst wbdata32", wbData32, 0);
    check("rst misalign32", misalignErr32, 0);
    check("rst proto32", protoErr32, 0);
    check("rst ready32", reqReady32, 1);
    rst = 1'b0;
    @(negedge clk);

    // Stores: lane enables and replication
    issue("sb", SB, 32'h13, 32'h0000_00AB, 5'd0);
    checkReq("sb", 32'h10, 4'b0001, 32'h10, 8'h10);
    check("sb wd32", memWdata32, 32'hABAB_ABAB);
    check("sb wd64", memWdata64, 64'hABAB_ABAB_ABAB_ABAB);
    issue("sh", SH, 32'h12, 32'h0000_1234, 5'd0);
    checkReq("sh", 32'h10, 4'b0011, 32'h10, 8'h30);
    check("sh wd32", memWdata32, 32'h1234_1234);
    check("sh wd64", memWdata64, 64'h1234_1234_1234_1234);
    issue("sw", SW, 32'h08, 32'hDEAD_BEEF, 5'd0);
    checkReq("sw", 32'h08, 4'b1111, 32'h08, 8'hF0);
    check("sw wd32", memWdata32, 32'hDEAD_BEEF);
    check("sw wd64", memWdata64, 64'hDEAD_BEEF_DEAD_BEEF);
    @(negedge clk);
    check("store drain mvalid32", memReqValid32, 0);

    // Loads: lane select and extension (64-bit bus sees the word in both halves)
    issue("lb0", LB, 32'h20, 32'h0, 5'd3);
    checkReq("lb0", 32'h20, 4'b0000, 32'h20, 8'h00);
    respond("lb0", 32'h8123_45F6, 64'h8123_45F6_8123_45F6, 5'd3, 32'hFFFF_FF81, 32'hFFFF_FF81);
    issue("lbu3", LBU, 32'h23, 32'h0, 5'd4);
    respond("lbu3", 32'h8123_45F6, 64'h8123_45F6_8123_45F6, 5'd4, 32'h0000_00F6, 32'h0000_00F6);
    issue("lh2", LH, 32'h22, 32'h0, 5'd5);
    respond("lh2", 32'h8123_45F6, 64'h8123_45F6_8123_45F6, 5'd5, 32'h0000_45F6, 32'h0000_45F6);
    issue("lw", LW, 32'h24, 32'h0, 5'd6);
    checkReq("lw", 32'h24, 4'b0000, 32'h20, 8'h00);
    respond("lw", 32'h8123_45F6, 64'h8123_45F6_8123_45F6, 5'd6, 32'h8123_45F6, 32'h8123_45F6);
    issue("lh0", LH, 32'h20, 32'h0, 5'd1);
    respond("lh0", 32'h8123_45F6, 64'h8123_45F6_8123_45F6, 5'd1, 32'hFFFF_8123, 32'hFFFF_8123);
    issue("lhu0", LHU, 32'h20, 32'h0, 5'd2);
    respond("lhu0", 32'h8123_45F6, 64'h8123_45F6_8123_45F6, 5'd2, 32'h0000_8123, 32'h0000_8123);

    // Misaligned LW: accepted, not issued, error pulse next cycle
    issue("mis", LW, 32'h06, 32'h0, 5'd9);
    check("mis mvalid32", memReqValid32, 0);
    check("mis mvalid64", memReqValid64, 0);
    check("mis err32", misalignErr32, 1);
    check("mis err64", misalignErr64, 1);
    @(negedge clk);
    check("mis err32 end", misalignErr32, 0);
    check("mis wbv32", wbValid32, 0);
    check("mis ready32", reqReady32, 1);

    // Two outstanding loads fill the FIFO; responses return in issue order
    issue("out1", LW, 32'h30, 32'h0, 5'd7);
    issue("out2", LB, 32'h31, 32'h0, 5'd8);
    check("full ready32", reqReady32, 0);
    check("full ready64", reqReady64, 0);
    @(negedge clk);
    check("full hold ready32", reqReady32, 0);
    respond("out1", 32'h1122_3344, 64'h1122_3344_1122_3344, 5'd7, 32'h1122_3344, 32'h1122_3344);
    check("after pop ready32", reqReady32, 1);
    check("after pop ready64", reqReady64, 1);
    respond("out2", 32'hAAF0_0000, 64'hAAF0_0000_AAF0_0000, 5'd8, 32'hFFFF_FFF0, 32'hFFFF_FFF0);

    // Memory backpressure: request held stable, a waiting op is blocked
    mem_req_ready = 1'b0;
    issue("bp", SW, 32'h40, 32'hCAFE_F00D, 5'd0);
    req_valid = 1'b1; req_op = SB; req_addr = 32'h55; req_wdata = 32'h0000_005A;
    for (int i = 0; i < 5; i++) begin
      #1;
      checkReq("bp hold", 32'h40, 4'b1111, 32'h40, 8'hF0);
      check("bp wd32", memWdata32, 32'hCAFE_F00D);
      check("bp wd64", memWdata64, 64'hCAFE_F00D_CAFE_F00D);
      check("bp ready32", reqReady32, 0);
      check("bp ready64", reqReady64, 0);
      @(negedge clk);
    end
    mem_req_ready = 1'b1;
    #1;
    check("bp release ready32", reqReady32, 1);
    @(negedge clk);
    req_valid = 1'b0;
    checkReq("bp next", 32'h54, 4'b0100, 32'h50, 8'h04);
    check("bp next wd32", memWdata32, 32'h5A5A_5A5A);
    check("bp next wd64", memWdata64, 64'h5A5A_5A5A_5A5A_5A5A);
    @(negedge clk);

    // 64-bit specific lanes (distinct upper/lower words) with two outstanding loads
    issue("w64 sw", SW, 32'h104, 32'h0102_0304, 5'd0);
    checkReq("w64 sw", 32'h104, 4'b1111, 32'h100, 8'h0F);
    check("w64 sw wd64", memWdata64, 64'h0102_0304_0102_0304);
    issue("w64 sb", SB, 32'h105, 32'h0000_007E, 5'd0);
    checkReq("w64 sb", 32'h104, 4'b0100, 32'h100, 8'h04);
    check("w64 sb wd64", memWdata64, 64'h7E7E_7E7E_7E7E_7E7E);
    issue("w64 lb", LB, 32'h107, 32'h0, 5'd10);
    issue("w64 lw", LW, 32'h104, 32'h0, 5'd11);
    check("w64 full ready64", reqReady64, 0);
    respond("w64 lb", 32'h8123_45F6, 64'h0011_2233_4455_6689, 5'd10, 32'hFFFF_FFF6, 32'hFFFF_FF89);
    check("w64 pop ready64", reqReady64, 1);
    respond("w64 lw", 32'h8123_45F6, 64'h0011_2233_4455_6689, 5'd11, 32'h8123_45F6, 32'h4455_6689);
    issue("w64 lhu", LHU, 32'h102, 32'h0, 5'd12);
    respond("w64 lhu", 32'h8123_45F6, 64'h0011_2233_4455_6689, 5'd12, 32'h0000_45F6, 32'h0000_2233);

    // Reset with a load pending, then a late response
    issue("rstp", LW, 32'h50, 32'h0, 5'd9);
    rst = 1'b1;
    #1;
    check("rstp mvalid32", memReqValid32, 0);
    check("rstp ready32", reqReady32, 1);
    @(negedge clk);
    rst = 1'b0;
    mem_rsp_valid = 1'b1;
    rdata32 = 32'h1234_5678;
    rdata64 = 64'h1234_5678_1234_5678;
    #1;
    check("late wbv32", wbValid32, 0);
    check("late wbv64", wbValid64, 0);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    check("late proto32", protoErr32, 1);
    check("late proto64", protoErr64, 1);
    check("late wbv32 reg", wbValid32, 0);
    @(negedge clk);
    check("proto sticky32", protoErr32, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("proto cleared32", protoErr32, 0);
    check("proto cleared64", protoErr64, 0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
